// File: rtl/je_pkg.sv
`default_nettype none
// ============================================================================
// Module  : je_pkg
// Purpose : Shared definitions for the JPEG entropy-coder back end
//           (je_bit_packer / je_byte_stuffer): FSM state encoding and the
//           JPEG byte constants used for stuffing, padding and the EOI marker.
// Revision: 1.0 - initial release
// ============================================================================
package je_pkg;

  // Packer sequencing states. ST_STUFF is part of the encoding so that all
  // sequencing phases have a name, but stuff insertion is performed by
  // je_byte_stuffer; the packer simply stalls on the byte handshake while a
  // stuff byte is in flight.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EMIT    = 3'd1,
    ST_STUFF   = 3'd2,
    ST_PAD     = 3'd3,
    ST_MARK_FF = 3'd4,
    ST_MARK_D9 = 3'd5,
    ST_DONE    = 3'd6
  } je_state_e;

  localparam logic [7:0] STUFF_BYTE    = 8'h00;  // inserted after a data 0xFF
  localparam logic [7:0] MARKER_PREFIX = 8'hFF;  // byte value that triggers stuffing
  localparam logic [7:0] EOI_CODE      = 8'hD9;  // end-of-image marker code
  localparam logic       PAD_BIT       = 1'b1;   // fill value for the last partial byte

endpackage : je_pkg
`default_nettype wire

// File: rtl/je_byte_stuffer.sv
`default_nettype none
// ============================================================================
// Module  : je_byte_stuffer
// Purpose : Single-entry output byte register in front of the byte FIFO.
//           Accepts bytes over a valid/ready pair, presents them to the FIFO
//           gated by fifo_full, and inserts 0x00 after every consumed data
//           0xFF (bytes flagged in_no_stuff, i.e. markers, are not stuffed).
// Ports   : clk, reset        - clock, synchronous active-high reset
//           in_valid/in_ready - byte handshake from the packer
//           in_data           - byte to emit
//           in_no_stuff       - byte is a marker byte; skip stuffing
//           fifo_data/_write  - to sc_fifo data_in / write
//           fifo_full         - from sc_fifo full
//           busy              - a byte (data or stuff) is still pending
// Revision: 1.0 - initial release
// ============================================================================
module je_byte_stuffer
  import je_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_no_stuff,
  output logic       in_ready,
  output logic [7:0] fifo_data,
  output logic       fifo_write,
  input  logic       fifo_full,
  output logic       busy
);

  logic [7:0] obyte_q, obyte_d;
  logic       pending_q, pending_d;
  logic       no_stuff_q, no_stuff_d;
  logic       consume;
  logic       need_stuff;

  assign consume    = pending_q && !fifo_full;
  assign need_stuff = consume && (obyte_q == MARKER_PREFIX) && !no_stuff_q;
  // A new byte can enter when the register is empty or is being drained this
  // cycle, unless the drained byte must be followed by a stuff byte.
  assign in_ready   = !pending_q || (consume && !need_stuff);

  assign fifo_data  = obyte_q;
  assign fifo_write = consume;
  assign busy       = pending_q;

  always_comb begin
    obyte_d    = obyte_q;
    pending_d  = pending_q;
    no_stuff_d = no_stuff_q;
    if (need_stuff) begin
      obyte_d    = STUFF_BYTE;
      pending_d  = 1'b1;
      no_stuff_d = 1'b1;
    end else if (in_valid && in_ready) begin
      obyte_d    = in_data;
      pending_d  = 1'b1;
      no_stuff_d = in_no_stuff;
    end else if (consume) begin
      pending_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      obyte_q    <= 8'h00;
      pending_q  <= 1'b0;
      no_stuff_q <= 1'b0;
    end else begin
      obyte_q    <= obyte_d;
      pending_q  <= pending_d;
      no_stuff_q <= no_stuff_d;
    end
  end

endmodule : je_byte_stuffer
`default_nettype wire

// File: rtl/je_bit_packer.sv
`default_nettype none
// ============================================================================
// Module  : je_bit_packer
// Purpose : Entropy-coder back end. Packs variable-length code words MSB
//           first into bytes, applies 0xFF -> 0xFF 0x00 stuffing (via
//           je_byte_stuffer), pads the final partial byte with 1s on flush
//           and writes into the downstream byte FIFO honouring fifo_full.
// Config  : JE_EOI_INSERT_EN - when defined, a flush also appends the EOI
//           marker 0xFF 0xD9 (unstuffed) before flush_done.
// Ports   : clk, reset         - clock, synchronous active-high reset
//           code_valid/_bits/_len, code_ready - input word handshake
//           flush, flush_done  - pad/drain request and completion pulse
//           fifo_data/_write, fifo_full      - byte FIFO interface
//           byte_cnt           - bytes written (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module je_bit_packer
  import je_pkg::*;
#(
  parameter int CODE_WIDTH = 32,
  parameter int LEN_WIDTH  = 6,
  parameter int BCNT_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  code_valid,
  input  logic [CODE_WIDTH-1:0] code_bits,
  input  logic [LEN_WIDTH-1:0]  code_len,
  output logic                  code_ready,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [7:0]            fifo_data,
  output logic                  fifo_write,
  input  logic                  fifo_full,
  output logic [BCNT_WIDTH-1:0] byte_cnt
);

  localparam int ACC_W = CODE_WIDTH + 8;
  localparam int NB_W  = $clog2(ACC_W);

`ifdef JE_EOI_INSERT_EN
  localparam je_state_e AFTER_PAD = ST_MARK_FF;
`else
  localparam je_state_e AFTER_PAD = ST_DONE;
`endif

  je_state_e             state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;       // valid bits right-aligned in [nbits-1:0]
  logic [NB_W-1:0]       nbits_q, nbits_d;
  logic [BCNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;

  logic             accept, take_flush;
  logic [ACC_W-1:0] code_mask, code_masked, acc_cat;
  logic [NB_W-1:0]  nb_cat, nb_rem;
  logic [7:0]       top_byte, pad_byte;
  logic             byte_valid, byte_ready, byte_no_stuff;
  logic [7:0]       byte_data;
  logic             stuffer_busy;

  assign code_ready = !reset && (state_q == ST_IDLE) && (nbits_q < NB_W'(8)) && !stuffer_busy;
  assign accept     = code_valid && code_ready;
  assign take_flush = flush && code_ready;

  // Append the masked code below the residual bits. Bits above nbits in the
  // accumulator are don't-care: extraction only ever looks at the 8 bits
  // just below the current nbits.
  assign code_mask   = ~({ACC_W{1'b1}} << code_len);
  assign code_masked = ACC_W'(code_bits) & code_mask;
  assign acc_cat     = accept ? ((acc_q << code_len) | code_masked) : acc_q;
  assign nb_cat      = accept ? (nbits_q + NB_W'(code_len)) : nbits_q;
  assign nb_rem      = nb_cat - NB_W'(8);
  assign top_byte    = 8'(acc_cat >> nb_rem);
  // Only meaningful for nb_cat in 1..7: residual bits at the top, 1s below.
  assign pad_byte    = 8'(acc_cat << (NB_W'(8) - nb_cat)) | ({8{PAD_BIT}} >> nb_cat);

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    nbits_d       = nbits_q;
    byte_valid    = 1'b0;
    byte_data     = top_byte;
    byte_no_stuff = 1'b0;
    flush_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept || take_flush) begin
          acc_d   = acc_cat;
          nbits_d = nb_cat;
          // The stuffer is empty whenever code_ready is high, so the first
          // byte is handed over in the accept cycle without waiting.
          if (nb_cat >= NB_W'(8)) begin
            byte_valid = 1'b1;
            nbits_d    = nb_rem;
          end
          if (take_flush) begin
            state_d = ST_PAD;
          end else if (nb_cat >= NB_W'(16)) begin
            state_d = ST_EMIT;
          end
        end
      end

      ST_EMIT: begin
        if (nbits_q >= NB_W'(8)) begin
          byte_valid = 1'b1;
          if (byte_ready) begin
            nbits_d = nb_rem;
            if (nb_rem < NB_W'(8)) begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PAD: begin
        // Whole bytes left over from a code+flush are drained first.
        if (nbits_q >= NB_W'(8)) begin
          byte_valid = 1'b1;
          if (byte_ready) begin
            nbits_d = nb_rem;
          end
        end else if (nbits_q != '0) begin
          byte_valid = 1'b1;
          byte_data  = pad_byte;
          if (byte_ready) begin
            nbits_d = '0;
            state_d = AFTER_PAD;
          end
        end else begin
          state_d = AFTER_PAD;
        end
      end

`ifdef JE_EOI_INSERT_EN
      ST_MARK_FF: begin
        byte_valid    = 1'b1;
        byte_data     = MARKER_PREFIX;
        byte_no_stuff = 1'b1;
        if (byte_ready) begin
          state_d = ST_MARK_D9;
        end
      end

      ST_MARK_D9: begin
        byte_valid    = 1'b1;
        byte_data     = EOI_CODE;
        byte_no_stuff = 1'b1;
        if (byte_ready) begin
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        // Wait until the last byte (and any stuff byte) has left the stuffer.
        if (!stuffer_busy) begin
          flush_done = !reset;
          acc_d      = '0;
          nbits_d    = '0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign byte_cnt_d = byte_cnt_q + BCNT_WIDTH'(fifo_write);
  assign byte_cnt   = byte_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      nbits_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      nbits_q    <= nbits_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  je_byte_stuffer u_stuffer (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (byte_valid),
    .in_data     (byte_data),
    .in_no_stuff (byte_no_stuff),
    .in_ready    (byte_ready),
    .fifo_data   (fifo_data),
    .fifo_write  (fifo_write),
    .fifo_full   (fifo_full),
    .busy        (stuffer_busy)
  );

endmodule : je_bit_packer
`default_nettype wire

// File: tb/tb_je_bit_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_je_bit_packer
// Purpose : Directed self-checking bench for je_bit_packer: reset state,
//           0xFF stuffing, zero-length/masked codes, two-byte codes, flush
//           padding, fifo_full back-pressure, reset mid-stream and the flush
//           tail (EOI marker when JE_EOI_INSERT_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
module tb_je_bit_packer;

  localparam int CW = 32;
  localparam int LW = 6;
  localparam int BW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          code_valid = 1'b0;
  logic [CW-1:0] code_bits = '0;
  logic [LW-1:0] code_len = '0;
  logic          code_ready;
  logic          flush = 1'b0;
  logic          flush_done;
  logic [7:0]    fifo_data;
  logic          fifo_write;
  logic          fifo_full = 1'b0;
  logic [BW-1:0] byte_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BW-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  je_bit_packer #(.CODE_WIDTH(CW), .LEN_WIDTH(LW), .BCNT_WIDTH(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code_bits  (code_bits),
    .code_len   (code_len),
    .code_ready (code_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .fifo_data  (fifo_data),
    .fifo_write (fifo_write),
    .fifo_full  (fifo_full),
    .byte_cnt   (byte_cnt)
  );

  // Illegal lengths must never be driven by this bench.
  always @(posedge clk) begin
    if (!reset && code_valid) begin
      assert (code_len <= LW'(CW)) else $error("code_len %0d exceeds CODE_WIDTH", code_len);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++; if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b want 0", fifo_write); end
    n_checks++; if (fifo_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", fifo_data); end
    n_checks++; if (code_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", code_ready); end
    n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", flush_done); end
    n_checks++; if (byte_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", byte_cnt); end
    reset = 1'b0;
    #1;
    n_checks++; if (code_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", code_ready); end
    exp_cnt = '0;
  endtask

  // 0x1F/5 then 0x7/3 -> 0xFF followed by stuffed 0x00 on the next cycle.
  task automatic test_stuff();
    code_valid = 1'b1; code_bits = 32'h1F; code_len = 6'd5;
    step();
    n_checks++; if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL stuff_nowrite: got %b want 0", fifo_write); end
    n_checks++; if (code_ready !== 1'b1) begin n_fail++; $display("FAIL stuff_ready5: got %b want 1", code_ready); end
    code_bits = 32'h7; code_len = 6'd3;
    step();
    code_valid = 1'b0;
    n_checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'hFF) begin n_fail++; $display("FAIL stuff_ff: got w=%b d=%h want w=1 d=ff", fifo_write, fifo_data); end
    step();
    n_checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'h00) begin n_fail++; $display("FAIL stuff_00: got w=%b d=%h want w=1 d=00", fifo_write, fifo_data); end
    step();
    exp_cnt = exp_cnt + 2;
    n_checks++; if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL stuff_end: got %b want 0", fifo_write); end
    n_checks++; if (byte_cnt !== exp_cnt) begin n_fail++; $display("FAIL stuff_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
  endtask

  // Zero-length word is a no-op; bits above code_len are ignored.
  task automatic test_len_mask();
    code_valid = 1'b1; code_bits = 32'hFFFF_FFFF; code_len = 6'd0;
    step();
    n_checks++; if (fifo_write !== 1'b0 || code_ready !== 1'b1) begin n_fail++; $display("FAIL len0: got w=%b rdy=%b want w=0 rdy=1", fifo_write, code_ready); end
    code_bits = 32'hFFFF_FF01; code_len = 6'd8;
    step();
    code_valid = 1'b0;
    n_checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'h01) begin n_fail++; $display("FAIL mask_byte: got w=%b d=%h want w=1 d=01", fifo_write, fifo_data); end
    step();
    exp_cnt = exp_cnt + 1;
    n_checks++; if (byte_cnt !== exp_cnt) begin n_fail++; $display("FAIL mask_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
  endtask

  // 16-bit code -> two bytes on consecutive cycles, no residual.
  task automatic test_back_to_back();
    code_valid = 1'b1; code_bits = 32'hABCD; code_len = 6'd16;
    step();
    code_valid = 1'b0;
    n_checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'hAB) begin n_fail++; $display("FAIL b2b_ab: got w=%b d=%h want w=1 d=ab", fifo_write, fifo_data); end
    n_checks++; if (code_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy1: got %b want 0", code_ready); end
    step();
    n_checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'hCD) begin n_fail++; $display("FAIL b2b_cd: got w=%b d=%h want w=1 d=cd", fifo_write, fifo_data); end
    n_checks++; if (code_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy2: got %b want 0", code_ready); end
    step();
    exp_cnt = exp_cnt + 2;
    n_checks++; if (fifo_write !== 1'b0 || code_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_end: got w=%b rdy=%b want w=0 rdy=1", fifo_write, code_ready); end
    n_checks++; if (byte_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
  endtask

  // Code with flush in the same cycle: 101 + 11111 = 0xBF, then
  // 1111111 + 1 = 0xFF which must be stuffed before flush_done.
  task automatic test_flush_pad();
    code_valid = 1'b1; flush = 1'b1; code_bits = 32'h5; code_len = 6'd3;
    step();
    code_valid = 1'b0; flush = 1'b0;
    n_checks++; if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL pad_early: got %b want 0", fifo_write); end
    step();
    n_checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'hBF) begin n_fail++; $display("FAIL pad_bf: got w=%b d=%h want w=1 d=bf", fifo_write, fifo_data); end
    n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL pad_done_early: got %b want 0", flush_done); end
    step();
    n_checks++; if (flush_done !== 1'b1 || fifo_write !== 1'b0) begin n_fail++; $display("FAIL pad_done: got done=%b w=%b want done=1 w=0", flush_done, fifo_write); end
    step();
    n_checks++; if (flush_done !== 1'b0 || code_ready !== 1'b1) begin n_fail++; $display("FAIL pad_done_pulse: got done=%b rdy=%b want done=0 rdy=1", flush_done, code_ready); end
    exp_cnt = exp_cnt + 1;

    code_valid = 1'b1; flush = 1'b1; code_bits = 32'h7F; code_len = 6'd7;
    step();
    code_valid = 1'b0; flush = 1'b0;
    step();
    n_checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'hFF) begin n_fail++; $display("FAIL padff_ff: got w=%b d=%h want w=1 d=ff", fifo_write, fifo_data); end
    step();
    n_checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'h00 || flush_done !== 1'b0) begin n_fail++; $display("FAIL padff_00: got w=%b d=%h done=%b want w=1 d=00 done=0", fifo_write, fifo_data, flush_done); end
    step();
    n_checks++; if (flush_done !== 1'b1) begin n_fail++; $display("FAIL padff_done: got %b want 1", flush_done); end
    step();
    exp_cnt = exp_cnt + 2;
    n_checks++; if (byte_cnt !== exp_cnt) begin n_fail++; $display("FAIL pad_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
  endtask

  // Pending byte held for 5 cycles of fifo_full, then written exactly once.
  task automatic test_fifo_full();
    fifo_full = 1'b1;
    code_valid = 1'b1; code_bits = 32'h5A; code_len = 6'd8;
    step();
    code_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (fifo_write !== 1'b0 || fifo_data !== 8'h5A) begin n_fail++; $display("FAIL full_hold%0d: got w=%b d=%h want w=0 d=5a", k, fifo_write, fifo_data); end
      if (k < 4) step();
    end
    fifo_full = 1'b0;
    #1;
    n_checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'h5A) begin n_fail++; $display("FAIL full_release: got w=%b d=%h want w=1 d=5a", fifo_write, fifo_data); end
    step();
    exp_cnt = exp_cnt + 1;
    n_checks++; if (fifo_write !== 1'b0 || byte_cnt !== exp_cnt) begin n_fail++; $display("FAIL full_once: got w=%b cnt=%0d want w=0 cnt=%0d", fifo_write, byte_cnt, exp_cnt); end
  endtask

  // Reset while 0xFF awaits its stuff byte: everything discarded.
  task automatic test_reset_mid();
    code_valid = 1'b1; code_bits = 32'hFF; code_len = 6'd8;
    step();
    code_valid = 1'b0;
    n_checks++; if (fifo_data !== 8'hFF) begin n_fail++; $display("FAIL rmid_ff: got %h want ff", fifo_data); end
    reset = 1'b1;
    step();
    n_checks++; if (fifo_write !== 1'b0 || byte_cnt !== '0) begin n_fail++; $display("FAIL rmid_clear: got w=%b cnt=%0d want w=0 cnt=0", fifo_write, byte_cnt); end
    reset = 1'b0;
    exp_cnt = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL rmid_no00_%0d: got w=%b d=%h want w=0", k, fifo_write, fifo_data); end
    end
  endtask

  // Flush with no residual bits.
  task automatic test_flush_tail();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL tail_nowrite: got %b want 0", fifo_write); end
`ifdef JE_EOI_INSERT_EN
    step();
    step();
    n_checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'hFF) begin n_fail++; $display("FAIL eoi_ff: got w=%b d=%h want w=1 d=ff", fifo_write, fifo_data); end
    step();
    n_checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'hD9) begin n_fail++; $display("FAIL eoi_d9: got w=%b d=%h want w=1 d=d9", fifo_write, fifo_data); end
    step();
    n_checks++; if (flush_done !== 1'b1 || fifo_write !== 1'b0) begin n_fail++; $display("FAIL eoi_done: got done=%b w=%b want done=1 w=0", flush_done, fifo_write); end
    exp_cnt = exp_cnt + 2;
`else
    step();
    n_checks++; if (flush_done !== 1'b1 || fifo_write !== 1'b0) begin n_fail++; $display("FAIL tail_done: got done=%b w=%b want done=1 w=0", flush_done, fifo_write); end
`endif
    step();
    n_checks++; if (flush_done !== 1'b0 || code_ready !== 1'b1) begin n_fail++; $display("FAIL tail_idle: got done=%b rdy=%b want done=0 rdy=1", flush_done, code_ready); end
    n_checks++; if (byte_cnt !== exp_cnt) begin n_fail++; $display("FAIL tail_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_stuff();
    test_len_mask();
    test_back_to_back();
    test_flush_pad();
    test_fifo_full();
    test_reset_mid();
    test_flush_tail();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_je_bit_packer
`default_nettype wire
